dm_access_ctrl: RTL and testbench

- MEM-stage initiator that issues pipeline loads/stores to a data memory over a req/ack handshake. Pairs with the data memory as the other end of the interface.
- Generates byte enables and aligns store data for byte, half and word stores.
- Extracts and sign/zero-extends load data.
- Detects misaligned addresses.
- Holds the pipeline via `stall` while a memory access is in flight. Times out on a missing `ack`.

---
 rtl/dm_access_pkg.sv | 15 +
 rtl/dm_lane_align.sv | 50 +++++
 rtl/dm_access_ctrl.sv | 139 +++++++++++++
 tb/tb_dm_access_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_pkg.sv
// Shared encodings for the MEM-stage data memory access controller.
package dm_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Little-endian byte-lane steering: store byte enables/replication, alignment check,
// and load extraction with sign/zero extension. Purely combinational.
module dm_lane_align
    import dm_access_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misaligned,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = mem_rdata[{addr_lo, 3'b000} +: 8];
    assign rd_half = mem_rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be         = 4'b0000;
        wdata_rep  = 32'h0;
        misaligned = 1'b0;
        rdata_ext  = 32'h0;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sign & rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
                rdata_ext  = {{16{sign & rd_half[15]}}, rd_half};
            end
            SZ_WORD: begin
                be         = 4'b1111;
                wdata_rep  = wdata;
                misaligned = |addr_lo;
                rdata_ext  = mem_rdata;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage load/store initiator: req/ack to data memory, stalls the pipeline while
// an access is in flight, flags misaligned ops and ack timeouts.
module dm_access_ctrl
    import dm_access_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        op_valid,
    input  logic        op_we,
    input  logic [1:0]  op_size,
    input  logic        op_sign,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              idle, busy, accept;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata, al_rdata;
    logic              al_mis;

    assign idle = (state_q == ST_IDLE);
    assign busy = (state_q == ST_BUSY);

    // One aligner serves both paths: the incoming op while idle, the latched op while busy.
    dm_lane_align u_align (
        .addr_lo    (idle ? op_addr[1:0] : addr_q[1:0]),
        .size       (idle ? op_size : size_q),
        .sign       (idle ? op_sign : sign_q),
        .wdata      (op_wdata),
        .mem_rdata  (mem_rdata),
        .be         (al_be),
        .wdata_rep  (al_wdata),
        .misaligned (al_mis),
        .rdata_ext  (al_rdata)
    );

    assign accept = idle & op_valid & ~al_mis;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = op_addr;
                    we_d    = op_we;
                    size_d  = op_size;
                    sign_d  = op_sign;
                    be_d    = al_be;
                    wdata_d = al_wdata;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ack) begin
                    rdata_d = we_q ? 32'h0 : al_rdata;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = 32'h0;
                    cnt_d   = '0;
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // Idle-state outputs depend on op inputs, so they are masked while reset is held.
    assign stall       = ~clr & (busy | accept);
    assign addr_err    = ~clr & idle & op_valid & al_mis;
    assign rdata_valid = (state_q == ST_RESP);
    assign bus_err     = (state_q == ST_ERR);
    assign rdata       = rdata_q;
    assign mem_req     = busy;
    assign mem_we      = busy & we_q;
    assign mem_be      = busy ? be_q : 4'b0000;
    assign mem_addr    = busy ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata   = busy ? wdata_q : 32'h0;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Transaction-level reference model with per-cycle expectations, directed and random ops.
module tb_dm_access_ctrl;
    import dm_access_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        clr;
    logic        op_valid, op_we, op_sign;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic        stall, rdata_valid, addr_err, bus_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dm_access_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .clr(clr),
        .op_valid(op_valid), .op_we(op_we), .op_size(op_size), .op_sign(op_sign),
        .op_addr(op_addr), .op_wdata(op_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .addr_err(addr_err), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic        stall, req, rv, aerr, berr, we;
        logic [3:0]  be;
        logic [31:0] addr, wdata, rdata;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        exp_q[$];
    exp_t        ce;
    logic [31:0] hold;
    logic [31:0] mem [0:255];
    int          stall_cnt = 0;
    int          req_cnt = 0;
    logic [3:0]  last_be;
    logic [31:0] last_addr, last_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, act, expv);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] lo);
        if (sz == SZ_BYTE) return 4'(1 << int'(lo));
        if (sz == SZ_HALF) return lo[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == SZ_BYTE) return {4{wd[7:0]}};
        if (sz == SZ_HALF) return {2{wd[15:0]}};
        return wd;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [1:0] lo,
                                          input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        if (sz == SZ_WORD) return w;
        if (sz == SZ_BYTE) begin
            v = (w >> (8 * int'(lo))) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFFFF00;
        end else begin
            v = (w >> (16 * int'(lo[1]))) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    // Per-cycle comparison against the queued expectations.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(ce.stall));
            chk("mem_req", 32'(mem_req), 32'(ce.req));
            chk("rdata_valid", 32'(rdata_valid), 32'(ce.rv));
            chk("addr_err", 32'(addr_err), 32'(ce.aerr));
            chk("bus_err", 32'(bus_err), 32'(ce.berr));
            chk("rdata", rdata, ce.rdata);
            if (ce.req) begin
                chk("mem_we", 32'(mem_we), 32'(ce.we));
                chk("mem_be", 32'(mem_be), 32'(ce.be));
                chk("mem_addr", mem_addr, ce.addr);
                chk("mem_wdata", mem_wdata, ce.wdata);
            end
        end
        if (stall) stall_cnt++;
        if (mem_req) begin
            req_cnt++;
            last_be    = mem_be;
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
        end
    end

    task automatic step(input logic v, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic ack, input logic [31:0] rd, input exp_t e);
        @(posedge clk);
        #1;
        op_valid = v; op_we = we; op_size = sz; op_sign = sg;
        op_addr = a; op_wdata = wd; mem_ack = ack; mem_rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic idle_cyc(input logic ack);
        exp_t e;
        e = '0;
        e.rdata = hold;
        step(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, ack, $urandom, e);
    endtask

    // dly: BUSY cycle on which ack arrives (1 = immediate); outside 1..TO means never.
    task automatic do_op(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int dly);
        exp_t        e;
        logic        mis;
        int          n;
        logic [7:0]  idx;
        logic [31:0] mask, wrep;
        mis = (sz == 2'b11) || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a[1:0] != 2'b00);
        idx = a[9:2];
        e = '0;
        e.rdata = hold;
        if (mis) begin
            e.aerr = 1'b1;
            step(1'b1, we, sz, sg, a, wd, 1'($urandom), $urandom, e);
            return;
        end
        e.stall = 1'b1;
        step(1'b1, we, sz, sg, a, wd, 1'($urandom), $urandom, e);
        n = (dly >= 1 && dly <= TO) ? dly : TO;
        wrep = m_wd(sz, wd);
        for (int k = 1; k <= n; k++) begin
            e = '0;
            e.stall = 1'b1; e.req = 1'b1; e.we = we;
            e.be = m_be(sz, a[1:0]); e.addr = {a[31:2], 2'b00}; e.wdata = wrep;
            e.rdata = hold;
            step(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                 (k == dly), (k == dly) ? mem[idx] : $urandom, e);
        end
        e = '0;
        if (dly >= 1 && dly <= TO) begin
            if (we) begin
                mask = {{8{e.be[3] | m_be(sz, a[1:0]) >> 3 != 0}}, 24'h0};
                for (int b = 0; b < 4; b++)
                    mask[8*b +: 8] = m_be(sz, a[1:0])[b] ? 8'hFF : 8'h00;
                mem[idx] = (mem[idx] & ~mask) | (wrep & mask);
                $display("%0t: *%h <= %h %b", $time, {a[31:2], 2'b00}, wrep, m_be(sz, a[1:0]));
                hold = 32'h0;
            end else begin
                hold = m_ext(mem[idx], a[1:0], sz, sg);
            end
            e.rv = 1'b1;
        end else begin
            hold = 32'h0;
            e.berr = 1'b1;
        end
        e.rdata = hold;
        step(1'b1, we, sz, sg, a, wd, 1'($urandom), $urandom, e);
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, r0, szr, dr, dly;
        logic [1:0]  sz;
        logic [31:0] a;
        exp_t e;

        clr = 1'b1;
        op_valid = 1'b1; op_we = 1'b0; op_size = SZ_WORD; op_sign = 1'b0;
        op_addr = 32'h0; op_wdata = 32'h0; mem_ack = 1'b1; mem_rdata = 32'h0;
        hold = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        #12;
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_mem_req", 32'(mem_req), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_flags", {29'h0, rdata_valid, addr_err, bus_err}, 32'h0);
        @(posedge clk);
        #1;
        op_valid = 1'b0; mem_ack = 1'b0;
        clr = 1'b0;
        idle_cyc(1'b1);
        idle_cyc(1'b0);

        // sb to lane 3, ack on second busy cycle
        s0 = stall_cnt; r0 = req_cnt;
        do_op(1'b1, SZ_BYTE, 1'b0, 32'h103, 32'h000000AB, 2);
        sync();
        chk("sb_be", 32'(last_be), 32'h8);
        chk("sb_wdata", last_wdata, 32'hABABABAB);
        chk("sb_addr", last_addr, 32'h100);
        chk("sb_stall_cycles", 32'(stall_cnt - s0), 32'd3);

        mem[8'h80] = 32'h80017FFF;
        do_op(1'b0, SZ_HALF, 1'b1, 32'h202, 32'h0, 1);
        sync();
        chk("lh_rdata", rdata, 32'hFFFF8001);
        do_op(1'b0, SZ_HALF, 1'b0, 32'h202, 32'h0, 1);
        sync();
        chk("lhu_rdata", rdata, 32'h00008001);
        mem[8'h10] = 32'hFFFFFF7F;
        do_op(1'b0, SZ_BYTE, 1'b1, 32'h040, 32'h0, 3);
        sync();
        chk("lb_rdata", rdata, 32'h0000007F);

        s0 = stall_cnt; r0 = req_cnt;
        do_op(1'b0, SZ_WORD, 1'b0, 32'h006, 32'h0, 1);
        do_op(1'b1, SZ_HALF, 1'b0, 32'h001, 32'h1234, 1);
        do_op(1'b0, 2'b11, 1'b0, 32'h000, 32'h0, 1);
        sync();
        chk("misaligned_no_req", 32'(req_cnt - r0), 32'd0);
        chk("misaligned_no_stall", 32'(stall_cnt - s0), 32'd0);

        r0 = req_cnt;
        do_op(1'b0, SZ_WORD, 1'b0, 32'h080, 32'h0, 0);
        sync();
        chk("timeout_req_cycles", 32'(req_cnt - r0), 32'd16);
        chk("timeout_rdata", rdata, 32'h0);
        mem[8'h21] = 32'hCAFE0016;
        r0 = req_cnt;
        do_op(1'b0, SZ_WORD, 1'b0, 32'h084, 32'h0, TO);
        sync();
        chk("late_ack_req_cycles", 32'(req_cnt - r0), 32'd16);
        chk("late_ack_rdata", rdata, 32'hCAFE0016);

        // reset while busy: outputs must drop without waiting for an edge
        e = '0; e.stall = 1'b1; e.rdata = hold;
        step(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h11111111, 1'b0, 32'h0, e);
        e.req = 1'b1; e.we = 1'b1; e.be = 4'hF; e.addr = 32'h40; e.wdata = 32'h11111111;
        step(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h11111111, 1'b0, 32'h0, e);
        @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        chk("clr_mem_req", 32'(mem_req), 32'h0);
        chk("clr_stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        op_valid = 1'b0; mem_ack = 1'b1;
        #2;
        clr = 1'b0;
        hold = 32'h0;
        idle_cyc(1'b1);
        idle_cyc(1'b1);
        do_op(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 2);

        // back-to-back store then load of the same word
        s0 = stall_cnt; r0 = req_cnt;
        do_op(1'b1, SZ_WORD, 1'b0, 32'h0, 32'h5A5AC3C3, 1);
        do_op(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1);
        sync();
        chk("b2b_stall_cycles", 32'(stall_cnt - s0), 32'd4);
        chk("b2b_req_cycles", 32'(req_cnt - r0), 32'd2);
        chk("b2b_load_data", rdata, 32'h5A5AC3C3);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) idle_cyc(1'($urandom));
            szr = $urandom_range(0, 9);
            sz = (szr < 3) ? SZ_BYTE : (szr < 6) ? SZ_HALF : (szr < 9) ? SZ_WORD : 2'b11;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == SZ_HALF) a[0] = 1'b0;
                if (sz == SZ_WORD) a[1:0] = 2'b00;
            end
            dr = $urandom_range(0, 9);
            dly = (dr < 7) ? $urandom_range(1, 4) : (dr == 7) ? TO :
                  (dr == 8) ? TO + 1 : $urandom_range(5, TO - 1);
            do_op(1'($urandom), sz, 1'($urandom), a, $urandom, dly);
        end
        idle_cyc(1'b0);
        sync();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
